// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames by default, 8E1/8O1 when UART_RX_PARITY_EN is defined.
// Mid-bit sampling from a 2-flop synchronized line, falling-edge start detection.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX_in,
  output logic [7:0] RX_data_out,
  output logic       data_ready,
  output logic       parity_err,
  output logic       stop_err,
  output logic       RX_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
      $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
      $error("uart_rx: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          serr_q, serr_d;
  logic          busy_q, busy_d;
  logic          sync1_q, rx_s_q, rx_prev_q;
  logic          sample;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          perr_out_q, perr_out_d;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    serr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
    perr_out_d = 1'b0;
`endif
    sample = (baud_q == SAMPLE_AT);
    if (state_q != IDLE) begin
      baud_d = (baud_q == BAUD_MAX) ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        // Start only on a fresh 1->0 edge so a held-low (break) line stays idle.
        if (rx_prev_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (sample) state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          perr_d  = ((^shift_q) ^ rx_s_q) != PARITY_ODD[0];
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          state_d = IDLE;
          data_d  = shift_q;
          ready_d = 1'b1;
          serr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
          // A framing error masks any parity error on the same frame.
          perr_out_d = perr_q && rx_s_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      serr_q    <= 1'b0;
      busy_q    <= 1'b0;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      perr_out_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      serr_q    <= serr_d;
      busy_q    <= busy_d;
      sync1_q   <= RX_in;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      perr_out_q <= perr_out_d;
`endif
    end
  end

  assign RX_data_out = data_q;
  assign data_ready  = ready_q;
  assign stop_err    = serr_q;
  assign RX_busy     = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_out_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
